// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmitter feeder: word width and feeder state encoding.
package coax_pkg;

  localparam int COAX_WORD_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESENT = 3'd1,
    ST_RELEASE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DRAIN   = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/coax_word_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derive from the registered count.
module coax_word_fifo
  import coax_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = COAX_WORD_WIDTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/coax_tx_feeder.sv
// Feeds queued words to the coax transmitter, one load pulse per word, as one frame per start.
//
// state   | meaning
// IDLE    | waiting for start with a non-empty FIFO
// PRESENT | drive FIFO head onto tx_data, raise tx_load
// RELEASE | drop tx_load (transmitter captures), pop FIFO head
// SETTLE  | let tx_full catch up with the capture
// CHECK   | FIFO empty -> DRAIN; holding register busy -> wait; else next word
// DRAIN   | wait for the transmitter to finish the frame
module coax_tx_feeder
  import coax_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COAX_WORD_WIDTH-1:0] wr_data,
  input  logic                       wr_strobe,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [COUNT_WIDTH-1:0]     fifo_count,
  output logic                       overflow,
  input  logic                       overflow_clear,
  input  logic                       start,
  output logic                       busy,
  output logic [COAX_WORD_WIDTH-1:0] tx_data,
  output logic                       tx_load,
  input  logic                       tx_full,
  input  logic                       tx_active
);

  feeder_state_e               state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        tx_load_q, tx_load_d;
  logic [COAX_WORD_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                        overflow_q, overflow_d;
  logic                        fifo_pop;
  logic [COAX_WORD_WIDTH-1:0]  fifo_dout;

  coax_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (COAX_WORD_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_strobe),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy     = busy_q;
  assign tx_load  = tx_load_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

  // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clear) overflow_d = 1'b0;
    if (wr_strobe && fifo_full) overflow_d = 1'b1;
  end

  // Next-state and load-protocol outputs.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    tx_load_d = tx_load_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !fifo_empty) begin
          state_d = ST_PRESENT;
          busy_d  = 1'b1;
        end
      end
      ST_PRESENT: begin
        tx_data_d = fifo_dout;
        tx_load_d = 1'b1;
        state_d   = ST_RELEASE;
      end
      ST_RELEASE: begin
        tx_load_d = 1'b0;
        fifo_pop  = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (fifo_empty)    state_d = ST_DRAIN;
        else if (!tx_full) state_d = ST_PRESENT;
      end
      ST_DRAIN: begin
        if (!tx_active) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        tx_load_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      tx_load_q  <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      tx_load_q  <= tx_load_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_coax_tx_feeder.sv
// Bench for coax_tx_feeder: reference FIFO scoreboard plus a behavioural transmitter.
module tb_coax_tx_feeder;

  localparam int DEPTH = 16;
  localparam int FRAME = 24;   // 12 bits at 2 clocks per bit

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] wr_data = '0;
  logic       wr_strobe = 1'b0;
  logic       overflow_clear = 1'b0;
  logic       start = 1'b0;
  logic       fifo_full, fifo_empty, overflow, busy, tx_load;
  logic [4:0] fifo_count;
  logic [9:0] tx_data;
  logic       tx_full = 1'b0;
  logic       tx_active = 1'b0;
  logic       stall = 1'b0;

  coax_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_data        (wr_data),
    .wr_strobe      (wr_strobe),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .start          (start),
    .busy           (busy),
    .tx_data        (tx_data),
    .tx_load        (tx_load),
    .tx_full        (tx_full),
    .tx_active      (tx_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural transmitter: captures on load falling edge, holding register feeds shifter.
  logic       xm_load_prev = 1'b0;
  logic [9:0] xm_hold = '0;
  int         xm_cnt = 0;
  int         n_captures = 0;
  logic [9:0] tx_seen [$];

  always @(posedge clk) begin
    if (reset) begin
      xm_load_prev <= 1'b0;
      tx_full      <= 1'b0;
      tx_active    <= 1'b0;
      xm_cnt       <= 0;
    end else begin
      xm_load_prev <= tx_load;
      if (xm_cnt > 1) xm_cnt <= xm_cnt - 1;
      else if (tx_full && !stall) begin
        xm_cnt    <= FRAME;
        tx_active <= 1'b1;
        tx_full   <= 1'b0;
        tx_seen.push_back(xm_hold);
      end else begin
        xm_cnt    <= 0;
        tx_active <= 1'b0;
      end
      if (xm_load_prev && !tx_load) begin
        xm_hold    <= tx_data;
        tx_full    <= 1'b1;
        n_captures <= n_captures + 1;
      end
    end
  end

  // Reference FIFO model and scoreboard, evaluated mid-cycle.
  logic [9:0] ref_q [$];
  logic [9:0] sent_ref [$];
  logic       exp_ovf = 1'b0;
  int         cyc_n = 0;
  int         last_load = -1;
  int         act_rises = 0;
  logic       load_prev_m = 1'b0, busy_prev = 1'b0, act_prev = 1'b0;

  initial forever begin
    logic full_now, pop_now;
    @(negedge clk);
    cyc_n++;
    chk("fifo_count", 32'(fifo_count), 32'(ref_q.size()));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("fifo_full", 32'(fifo_full), 32'(ref_q.size() == DEPTH));
    chk("fifo_empty", 32'(fifo_empty), 32'(ref_q.size() == 0));
    if (!reset && tx_load && !load_prev_m) begin
      if (last_load >= 0) chk("load_spacing_ge4", 32'((cyc_n - last_load) >= 4), 32'd1);
      last_load = cyc_n;
    end
    pop_now = !reset && tx_load;
    if (pop_now) begin
      if (ref_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_load: got tx_data 0x%0h, expected no load", tx_data);
        pop_now = 1'b0;
      end else begin
        chk("tx_data", 32'(tx_data), 32'(ref_q[0]));
      end
    end
    if (busy_prev && !busy && !reset) chk("busy_fall_after_inactive", 32'(tx_active), 32'd0);
    if (!busy) last_load = -1;
    if (tx_active && !act_prev) act_rises++;
    if (reset) begin
      ref_q.delete();
      exp_ovf = 1'b0;
    end else begin
      full_now = (ref_q.size() == DEPTH);
      if (wr_strobe && full_now) exp_ovf = 1'b1;
      else if (overflow_clear)   exp_ovf = 1'b0;
      if (pop_now) sent_ref.push_back(ref_q.pop_front());
      if (wr_strobe && !full_now) ref_q.push_back(wr_data);
    end
    load_prev_m = tx_load;
    busy_prev   = busy;
    act_prev    = tx_active;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] w);
    wr_data   = w;
    wr_strobe = 1'b1;
    cyc();
    wr_strobe = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || tx_active || tx_full) && k < 3000) begin
      cyc();
      k++;
    end
    chk(name, 32'(k < 3000), 32'd1);
  endtask

  task automatic wait_load(input string name);
    int k = 0;
    while (!tx_load && k < 100) begin
      cyc();
      k++;
    end
    chk(name, 32'(k < 100), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_load"}, 32'(tx_load), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
  endtask

  initial begin
    int seen0, rises0, caps0, lat, bad, n;
    logic [9:0] w0, w1, d0;

    repeat (3) cyc();
    chk_reset_outputs("reset");
    reset = 1'b0;
    cyc();

    // Three-word frame with extreme values.
    wr(10'h3FF); wr(10'h001); wr(10'h2AA);
    seen0 = tx_seen.size(); rises0 = act_rises;
    go();
    lat = 0;
    while (!tx_load && lat < 10) begin cyc(); lat++; end
    chk("start_to_load_cycles", lat, 1);
    wait_idle("frame3_done");
    chk("frame3_words", tx_seen.size() - seen0, 3);
    chk("frame3_one_frame", act_rises - rises0, 1);
    chk("frame3_w0", 32'(tx_seen[seen0]), 32'h3FF);
    chk("frame3_w1", 32'(tx_seen[seen0+1]), 32'h001);
    chk("frame3_w2", 32'(tx_seen[seen0+2]), 32'h2AA);
    chk("frame3_busy", 32'(busy), 32'd0);

    // Overflow: 20 writes into 16 slots.
    for (int i = 0; i < 20; i++) begin
      wr(10'($urandom));
      if (i == 15) chk("full_after_16", 32'(fifo_full), 32'd1);
    end
    chk("overflow_set", 32'(overflow), 32'd1);
    wr_strobe = 1'b1; overflow_clear = 1'b1; cyc();
    wr_strobe = 1'b0;
    chk("overflow_set_wins", 32'(overflow), 32'd1);
    cyc();
    overflow_clear = 1'b0;
    chk("overflow_cleared", 32'(overflow), 32'd0);
    seen0 = tx_seen.size(); rises0 = act_rises;
    go();
    wait_idle("frame16_done");
    chk("frame16_words", tx_seen.size() - seen0, 16);
    chk("frame16_one_frame", act_rises - rises0, 1);

    // Transmitter holding register stays full.
    wr(10'($urandom)); wr(10'($urandom)); wr(10'($urandom));
    stall = 1'b1;
    go();
    wait_load("stall_first_load");
    repeat (4) cyc();
    d0 = tx_data; bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (tx_load || tx_data !== d0) bad++;
    end
    chk("stall_no_load_stable_data", bad, 0);
    chk("stall_tx_full", 32'(tx_full), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    wait_idle("stall_done");

    // Start with the FIFO empty.
    go();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || tx_load) bad++;
      cyc();
    end
    chk("empty_start_ignored", bad, 0);

    // Word appended while the first word is shifting.
    w0 = 10'($urandom); w1 = 10'($urandom);
    wr(w0); wr(w1);
    seen0 = tx_seen.size(); rises0 = act_rises;
    go();
    lat = 0;
    while (!tx_active && lat < 100) begin cyc(); lat++; end
    chk("midframe_active_seen", 32'(lat < 100), 32'd1);
    wr(10'h155);
    wait_idle("midframe_done");
    chk("midframe_words", tx_seen.size() - seen0, 3);
    chk("midframe_no_gap", act_rises - rises0, 1);
    chk("midframe_last", 32'(tx_seen[tx_seen.size()-1]), 32'h155);

    // Reset during RELEASE.
    wr(10'($urandom)); wr(10'($urandom)); wr(10'($urandom));
    go();
    wait_load("reset_test_load");
    caps0 = n_captures;
    reset = 1'b1;
    cyc(); cyc();
    chk_reset_outputs("mid_reset");
    reset = 1'b0;
    repeat (10) cyc();
    chk("mid_reset_no_capture", n_captures - caps0, 0);
    chk("mid_reset_inactive", 32'(tx_active), 32'd0);

    // Randomized frames with occasional late writes.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) wr(10'($urandom));
      go();
      repeat ($urandom_range(0, 40)) cyc();
      if ($urandom_range(0, 1) == 1) wr(10'($urandom));
      wait_idle("rand_frame_done");
      for (int r = 0; r < 4 && !fifo_empty; r++) begin
        go();
        wait_idle("rand_leftover_done");
      end
    end

    chk("sent_total", tx_seen.size(), sent_ref.size());
    for (int i = 0; i < tx_seen.size() && i < sent_ref.size(); i++)
      chk("sent_word", 32'(tx_seen[i]), 32'(sent_ref[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
